key_debounce_sync: RTL and testbench
====================================

Name: key_debounce_sync

Overview:
- Input-conditioning stage directly upstream of the LED counter top. Takes the raw, asynchronous, active-low DE0-Nano push-buttons (KEY) and makes them usable by the counter's reset/enable logic.
- Synchronises each key into the EXTCLK domain and debounces it with a per-key stability counter.
- Emits a clean active-high level plus single-cycle press/release pulses for each key.

Parameters:
- NUM_KEYS, 2, number of independent keys handled.
- SYNC_STAGES, 2, synchroniser flop depth per key; minimum 2.
- DEBOUNCE_CYCLES, 500000, EXTCLK cycles a new level must stay stable before it is accepted (10 ms at 50 MHz); minimum 2.

Ports:
- EXTCLK  input  1  system clock, 50 MHz; all logic on its rising edge.
- RST_N  input  1  synchronous, active-low reset.
- KEY_RAW  input  NUM_KEYS  raw buttons, asynchronous, active-low (0 = pressed).
- KEY_LEVEL  output  NUM_KEYS  debounced state, active-high (1 = pressed).
- KEY_PRESS  output  NUM_KEYS  one-cycle pulse when a press is accepted.
- KEY_RELEASE  output  NUM_KEYS  one-cycle pulse when a release is accepted.

Behaviour:
- Clock and reset: one clock (EXTCLK). Reset RST_N is synchronous, active-low, sampled on EXTCLK rising edge.
- Reset values:
  - Synchroniser flops = 1 (released).
  - FSM = RELEASED, counter = 0.
  - KEY_LEVEL = 0, KEY_PRESS = 0, KEY_RELEASE = 0.
  - Reset asserted mid-debounce or while pressed returns to these values on that edge. No pulse is generated by reset.
- Synchroniser: KEY_RAW[i] passes through SYNC_STAGES flops. The internal signal pressed_s[i] is the inverted last stage.
- Per-key FSM, with all keys fully independent (simultaneous activity on several keys is legal):
  - RELEASED: pressed_s=1 -> WAIT_PRESS, cnt=0.
  - WAIT_PRESS:
    - pressed_s=0 -> RELEASED (bounce, abort, no pulse).
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
    - Otherwise cnt+1.
  - PRESSED: pressed_s=0 -> WAIT_RELEASE, cnt=0.
  - WAIT_RELEASE:
    - pressed_s=1 -> PRESSED (bounce, no pulse).
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> RELEASED.
    - Otherwise cnt+1.
- Counter: width $clog2(DEBOUNCE_CYCLES). It never wraps; it is held or cleared by the FSM.
- Outputs are registered and updated on the same edge the FSM enters PRESSED/RELEASED:
  - KEY_LEVEL = 1 in PRESSED and WAIT_RELEASE, 0 otherwise.
  - KEY_PRESS high exactly one cycle on WAIT_PRESS->PRESSED.
  - KEY_RELEASE high exactly one cycle on WAIT_RELEASE->RELEASED.
- Latency: KEY_RAW held stable; edge 1 = first edge sampling the new value. KEY_LEVEL changes and the pulse asserts on edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Held key: no repeated pulses.
- A bounce shorter than the window produces no output change and restarts the count on the next transition.
- KEY_PRESS and KEY_RELEASE are never high together for the same key.

Optional Feature:
- Macro: KEY_DEBOUNCE_TOGGLE_EN.
- When defined:
  - Adds output KEY_TOGGLE [NUM_KEYS], reset value 0.
  - Each bit inverts on the edge its KEY_PRESS asserts, so it is aligned with KEY_LEVEL rising. Intended as a latched enable for the counter stage.
  - Release and bounce do not affect it; reset clears it.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset default: RST_N=0 for 5 cycles with KEY_RAW=2'b00 -> all outputs 0 throughout reset. On release: KEY_LEVEL=2'b11 at edge SYNC_STAGES+DEBOUNCE_CYCLES+1, KEY_PRESS pulses once. Run with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, so this is edge 7.
- Clean press/release, DEBOUNCE_CYCLES=4: KEY_RAW[1] 1->0 held 20 cycles, then 0->1.
  - KEY_LEVEL[1] rises on edge 7; KEY_PRESS[1] high that single cycle.
  - After release: KEY_LEVEL[1] falls 7 edges later, KEY_RELEASE[1] pulse once.
  - KEY_*[0] stay 0 throughout.
- Bounce rejection: KEY_RAW[0] toggled low/high every 2 cycles for 30 cycles, then held high -> KEY_LEVEL[0]=0, no KEY_PRESS/KEY_RELEASE pulse.
- Bounce during hold: key pressed and accepted, then a 2-cycle high glitch -> KEY_LEVEL stays 1, no pulses. A later full release still yields exactly one KEY_RELEASE.
- Reset mid-debounce: KEY_RAW[0] low, RST_N=0 on edge 5 for 1 cycle, key still held.
  - No pulse before reset.
  - KEY_LEVEL[0] rises on edge 7 counted from the edge after reset release, with exactly one KEY_PRESS.
- Toggle (KEY_DEBOUNCE_TOGGLE_EN defined): three clean presses of KEY[1] -> KEY_TOGGLE[1] goes 0->1->0->1, each flip coincident with KEY_PRESS[1]. KEY_TOGGLE[0] stays 0.

Source files
------------

// File: rtl/key_debounce_sync.sv
// key_debounce_sync: input conditioning for the DE0-Nano push-buttons.
// Each raw key (asynchronous, active-low) is synchronised into EXTCLK,
// debounced by a per-key stability counter, and presented as an
// active-high level plus single-cycle press/release pulses.
// Optional: define KEY_DEBOUNCE_TOGGLE_EN to add KEY_TOGGLE, a per-key
// latch that flips on every accepted press.
module key_debounce_sync #(
    parameter int NUM_KEYS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                EXTCLK,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] KEY_RAW,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    ,
    output logic [NUM_KEYS-1:0] KEY_TOGGLE
`endif
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } key_state_t;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   pressed_s;
        key_state_t             state_q;
        key_state_t             state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   level_q;
        logic                   level_d;
        logic                   press_q;
        logic                   press_d;
        logic                   release_q;
        logic                   release_d;

        // Synchroniser chain; reset to the released (high) level so no
        // spurious press is seen when reset lifts.
        always_ff @(posedge EXTCLK) begin
            if (!RST_N) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], KEY_RAW[k]};
            end
        end

        assign pressed_s = ~sync_q[SYNC_STAGES-1];

        // State, counter and registered outputs.
        always_ff @(posedge EXTCLK) begin
            if (!RST_N) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Next-state, counter and output decode; outputs are computed from
        // the next state so they change on the same edge the FSM settles.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (pressed_s) begin
                        state_d = WAIT_PRESS;
                        cnt_d   = '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!pressed_s) begin
                        state_d = RELEASED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!pressed_s) begin
                        state_d = WAIT_RELEASE;
                        cnt_d   = '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (pressed_s) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
        end

        assign KEY_LEVEL[k]   = level_q;
        assign KEY_PRESS[k]   = press_q;
        assign KEY_RELEASE[k] = release_q;

`ifdef KEY_DEBOUNCE_TOGGLE_EN
        logic toggle_q;

        // Latched enable: flips on the edge the press pulse is registered.
        always_ff @(posedge EXTCLK) begin
            if (!RST_N) begin
                toggle_q <= 1'b0;
            end else if (press_d) begin
                toggle_q <= ~toggle_q;
            end
        end

        assign KEY_TOGGLE[k] = toggle_q;
`endif
    end

endmodule

// File: tb/tb_key_debounce_sync.sv
// tb_key_debounce_sync: directed bench for key_debounce_sync with
// SYNC_STAGES=2 and DEBOUNCE_CYCLES=4, so an accepted change lands on
// edge 7 after the raw input moves.
module tb_key_debounce_sync;

    logic       EXTCLK;
    logic       RST_N;
    logic [1:0] KEY_RAW;
    logic [1:0] KEY_LEVEL;
    logic [1:0] KEY_PRESS;
    logic [1:0] KEY_RELEASE;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    logic [1:0] KEY_TOGGLE;
`endif

    int checks   = 0;
    int failures = 0;
    int press_cnt0   = 0;
    int press_cnt1   = 0;
    int release_cnt0 = 0;
    int release_cnt1 = 0;

    key_debounce_sync #(
        .NUM_KEYS       (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .EXTCLK     (EXTCLK),
        .RST_N      (RST_N),
        .KEY_RAW    (KEY_RAW),
        .KEY_LEVEL  (KEY_LEVEL),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE)
`ifdef KEY_DEBOUNCE_TOGGLE_EN
        ,
        .KEY_TOGGLE (KEY_TOGGLE)
`endif
    );

    initial EXTCLK = 1'b0;
    always #5 EXTCLK = ~EXTCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        press_cnt0   = 0;
        press_cnt1   = 0;
        release_cnt0 = 0;
        release_cnt1 = 0;
    endtask

    // Advance one edge, sample 1 ns later, tally pulses and check exclusivity.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge EXTCLK);
            #1;
            if (KEY_PRESS[0] === 1'b1)   press_cnt0++;
            if (KEY_PRESS[1] === 1'b1)   press_cnt1++;
            if (KEY_RELEASE[0] === 1'b1) release_cnt0++;
            if (KEY_RELEASE[1] === 1'b1) release_cnt1++;
            chk("press_release_exclusive", {30'd0, KEY_PRESS & KEY_RELEASE}, 32'd0);
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] lvl, input logic [1:0] prs, input logic [1:0] rel);
        chk({tag, "_level"},   {30'd0, KEY_LEVEL},   {30'd0, lvl});
        chk({tag, "_press"},   {30'd0, KEY_PRESS},   {30'd0, prs});
        chk({tag, "_release"}, {30'd0, KEY_RELEASE}, {30'd0, rel});
    endtask

    initial begin
        RST_N   = 1'b0;
        KEY_RAW = 2'b00;

        // Reset default: both keys held during reset, outputs stay low.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            outs("in_reset", 2'b00, 2'b00, 2'b00);
        end
        RST_N = 1'b1;
        clear_counts();
        tick(6);
        outs("rst_rel_e6", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("rst_rel_e7", 2'b11, 2'b11, 2'b00);
        tick(1);
        outs("rst_rel_e8", 2'b11, 2'b00, 2'b00);
        tick(4);
        chk("rst_rel_press_cnt0", press_cnt0, 1);
        chk("rst_rel_press_cnt1", press_cnt1, 1);
        KEY_RAW = 2'b11;
        tick(7);
        outs("rst_rel_release_e7", 2'b00, 2'b00, 2'b11);
        tick(3);

        // Clean press/release on key 1.
        clear_counts();
        KEY_RAW = 2'b01;
        tick(6);
        outs("clean_e6", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("clean_e7", 2'b10, 2'b10, 2'b00);
        tick(13);
        outs("clean_hold", 2'b10, 2'b00, 2'b00);
        chk("clean_press_cnt1", press_cnt1, 1);
        KEY_RAW = 2'b11;
        tick(6);
        outs("clean_rel_e6", 2'b10, 2'b00, 2'b00);
        tick(1);
        outs("clean_rel_e7", 2'b00, 2'b00, 2'b10);
        tick(3);
        chk("clean_release_cnt1", release_cnt1, 1);
        chk("clean_key0_press", press_cnt0, 0);
        chk("clean_key0_release", release_cnt0, 0);

        // Bounce rejection on key 0: 2-cycle low/high toggling.
        clear_counts();
        for (int i = 0; i < 15; i++) begin
            KEY_RAW[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
            chk("bounce_level", {30'd0, KEY_LEVEL}, 32'd0);
        end
        KEY_RAW = 2'b11;
        tick(10);
        outs("bounce_end", 2'b00, 2'b00, 2'b00);
        chk("bounce_press_cnt0", press_cnt0, 0);
        chk("bounce_release_cnt0", release_cnt0, 0);

        // Bounce during hold on key 0.
        clear_counts();
        KEY_RAW = 2'b10;
        tick(7);
        outs("hold_e7", 2'b01, 2'b01, 2'b00);
        tick(5);
        KEY_RAW = 2'b11;
        tick(2);
        KEY_RAW = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("hold_glitch_level", {30'd0, KEY_LEVEL}, 32'd1);
        end
        chk("hold_press_cnt0", press_cnt0, 1);
        chk("hold_release_cnt0", release_cnt0, 0);
        KEY_RAW = 2'b11;
        tick(6);
        outs("hold_rel_e6", 2'b01, 2'b00, 2'b00);
        tick(1);
        outs("hold_rel_e7", 2'b00, 2'b00, 2'b01);
        tick(3);
        chk("hold_release_cnt0_final", release_cnt0, 1);

        // Reset mid-debounce on key 0 (reset sampled on edge 5).
        clear_counts();
        KEY_RAW = 2'b10;
        tick(4);
        outs("midrst_e4", 2'b00, 2'b00, 2'b00);
        RST_N = 1'b0;
        tick(1);
        outs("midrst_e5", 2'b00, 2'b00, 2'b00);
        chk("midrst_no_pulse", press_cnt0, 0);
        RST_N = 1'b1;
        tick(6);
        outs("midrst_after_e6", 2'b00, 2'b00, 2'b00);
        tick(1);
        outs("midrst_after_e7", 2'b01, 2'b01, 2'b00);
        tick(3);
        chk("midrst_press_cnt0", press_cnt0, 1);
        KEY_RAW = 2'b11;
        tick(7);
        outs("midrst_rel_e7", 2'b00, 2'b00, 2'b01);
        tick(3);

`ifdef KEY_DEBOUNCE_TOGGLE_EN
        // Toggle: reset clears it, then three presses on key 1.
        RST_N = 1'b0;
        tick(1);
        chk("toggle_reset", {30'd0, KEY_TOGGLE}, 32'd0);
        RST_N = 1'b1;
        tick(2);
        for (int p = 0; p < 3; p++) begin
            KEY_RAW = 2'b01;
            tick(6);
            chk("toggle_before", {30'd0, KEY_TOGGLE}, (p % 2 == 0) ? 32'd0 : 32'd2);
            tick(1);
            chk("toggle_flip", {30'd0, KEY_TOGGLE}, (p % 2 == 0) ? 32'd2 : 32'd0);
            chk("toggle_press", {30'd0, KEY_PRESS}, 32'd2);
            KEY_RAW = 2'b11;
            tick(10);
            chk("toggle_after_release", {30'd0, KEY_TOGGLE}, (p % 2 == 0) ? 32'd2 : 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
